// File: rtl/mux_nxw_reg.sv
// Registered NUM_IN x WIDTH lane selector with a valid/ready handshake and a 2-entry skid buffer.
// Latency 1 cycle; in_ready is ~skid_valid (registered), so out_ready never reaches in_ready combinationally.
module mux_nxw_reg #(
    parameter int NUM_IN = 40,
    parameter int WIDTH  = 35,
    parameter int SEL_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]          in_select,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_sel_err,
    output logic [7:0]                err_count
);
    localparam int OFF_W = SEL_W + $clog2(WIDTH) + 1;

    generate
        if ((2 ** SEL_W) < NUM_IN) begin : g_sel_chk
            $error("mux_nxw_reg: SEL_W is too narrow to address NUM_IN lanes");
        end
    endgenerate

    logic [OFF_W-1:0] lane_off;
    logic             sel_ok;
    logic [WIDTH-1:0] pay_dat;
    logic             pay_err;

    // Range check is one bit wider than the select so NUM_IN == 2**SEL_W still works.
    always_comb begin
        lane_off = OFF_W'(in_select) * OFF_W'(WIDTH);
        sel_ok   = {1'b0, in_select} < (SEL_W + 1)'(NUM_IN);
        pay_err  = ~sel_ok;
        pay_dat  = sel_ok ? WIDTH'(in_data >> lane_off) : '0;
    end

    logic             or_vld;
    logic [WIDTH-1:0] or_dat;
    logic             or_err;
    logic             sk_vld;
    logic [WIDTH-1:0] sk_dat;
    logic             sk_err;
    logic             accept;
    logic             emit;

    assign in_ready    = ~sk_vld;
    assign out_valid   = or_vld;
    assign out_data    = or_dat;
    assign out_sel_err = or_err;
    assign accept      = in_valid & ~sk_vld;
    assign emit        = or_vld & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_vld    <= 1'b0;
            or_dat    <= '0;
            or_err    <= 1'b0;
            sk_vld    <= 1'b0;
            sk_dat    <= '0;
            sk_err    <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (!or_vld) begin
                if (accept) begin
                    or_vld <= 1'b1;
                    or_dat <= pay_dat;
                    or_err <= pay_err;
                end
            end else if (!sk_vld) begin
                case ({accept, emit})
                    2'b11: begin
                        or_dat <= pay_dat;
                        or_err <= pay_err;
                    end
                    2'b10: begin
                        sk_vld <= 1'b1;
                        sk_dat <= pay_dat;
                        sk_err <= pay_err;
                    end
                    2'b01:   or_vld <= 1'b0;
                    default: ;
                endcase
            end else if (emit) begin
                // FULL: skid entry moves up; no accept is possible here
                or_dat <= sk_dat;
                or_err <= sk_err;
                sk_vld <= 1'b0;
            end

            if (accept && pay_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_nxw_reg.sv
// Directed and scoreboard checks of mux_nxw_reg in three parameterisations.
module tb_mux_nxw_reg;
    logic clk;
    logic rst;

    logic           a_iv, a_ir, a_ov, a_or, a_err;
    logic [40*35-1:0] a_dat;
    logic [5:0]     a_sel;
    logic [34:0]    a_od;
    logic [7:0]     a_cnt;

    logic           b_iv, b_ir, b_ov, b_or, b_err;
    logic [8*16-1:0] b_dat;
    logic [2:0]     b_sel;
    logic [15:0]    b_od;
    logic [7:0]     b_cnt;

    logic           c_iv, c_ir, c_ov, c_or, c_err;
    logic [5*16-1:0] c_dat;
    logic [2:0]     c_sel;
    logic [15:0]    c_od;
    logic [7:0]     c_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mux_nxw_reg #(.NUM_IN(40), .WIDTH(35), .SEL_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_dat),
        .in_select(a_sel), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_sel_err(a_err), .err_count(a_cnt));

    mux_nxw_reg #(.NUM_IN(8), .WIDTH(16), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_dat),
        .in_select(b_sel), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_sel_err(b_err), .err_count(b_cnt));

    mux_nxw_reg #(.NUM_IN(5), .WIDTH(16), .SEL_W(3)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_dat),
        .in_select(c_sel), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .out_sel_err(c_err), .err_count(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] lane_a(input int i);
        return 35'h1_0000_0000 + 35'(i);
    endfunction

    function automatic logic [35:0] exp_a(input logic [5:0] s);
        return (s < 6'd40) ? {1'b0, lane_a(int'(s))} : 36'h0_0000_0000 | 36'h8_0000_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_iv = 1'b1; a_sel = 6'd3; a_or = 1'b1;
        step();
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", a_ov); end
        n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", a_ir); end
        n_cmp++; if (a_od !== 35'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", a_od); end
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rst_sel_err: got %b want 0", a_err); end
        n_cmp++; if (a_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err_count: got %0d want 0", a_cnt); end
        a_iv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        a_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_iv = 1'b1; a_sel = 6'(i);
            step();
            n_cmp++; if (a_ov !== 1'b1 || a_od !== lane_a(i) || a_err !== 1'b0)
                begin n_bad++; $display("FAIL b2b_lane%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", i, a_ov, a_od, a_err, lane_a(i)); end
            n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, a_ir); end
        end
        a_iv = 1'b0;
        step();
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got out_valid %b want 0", a_ov); end
    endtask

    task automatic test_out_of_range();
        logic [5:0] sels [2];
        sels[0] = 6'd40; sels[1] = 6'd63;
        a_or = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_iv = 1'b1; a_sel = sels[i];
            step();
            n_cmp++; if (a_ov !== 1'b1 || a_od !== 35'h0 || a_err !== 1'b1)
                begin n_bad++; $display("FAIL oor_sel%0d: got v=%b d=%h e=%b want v=1 d=0 e=1", sels[i], a_ov, a_od, a_err); end
        end
        n_cmp++; if (a_cnt !== 8'd2) begin n_bad++; $display("FAIL oor_err_count: got %0d want 2", a_cnt); end
        a_iv = 1'b0;
        step();
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL oor_drain: got out_valid %b want 0", a_ov); end
    endtask

    task automatic test_stall();
        a_or = 1'b0;
        a_iv = 1'b1; a_sel = 6'd5;
        step();
        n_cmp++; if (a_ov !== 1'b1 || a_od !== lane_a(5) || a_ir !== 1'b1)
            begin n_bad++; $display("FAIL stall_one: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1", a_ov, a_od, a_ir, lane_a(5)); end
        a_sel = 6'd6;
        step();
        n_cmp++; if (a_ir !== 1'b0) begin n_bad++; $display("FAIL stall_full_rdy: got %b want 0", a_ir); end
        n_cmp++; if (a_od !== lane_a(5)) begin n_bad++; $display("FAIL stall_full_data: got %h want %h", a_od, lane_a(5)); end
        a_sel = 6'd9;
        step();
        n_cmp++; if (a_ov !== 1'b1 || a_od !== lane_a(5) || a_ir !== 1'b0)
            begin n_bad++; $display("FAIL stall_hold: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", a_ov, a_od, a_ir, lane_a(5)); end
        a_iv = 1'b0; a_or = 1'b1;
        step();
        n_cmp++; if (a_ov !== 1'b1 || a_od !== lane_a(6) || a_ir !== 1'b1)
            begin n_bad++; $display("FAIL stall_release: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1", a_ov, a_od, a_ir, lane_a(6)); end
        step();
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got out_valid %b want 0", a_ov); end
    endtask

    task automatic test_saturate();
        a_or = 1'b1;
        for (int k = 0; k < 300; k++) begin
            a_iv = 1'b1; a_sel = 6'(40 + (k % 24));
            step();
            if (k == 99) begin
                n_cmp++; if (a_cnt !== 8'd102) begin n_bad++; $display("FAIL sat_mid: got %0d want 102", a_cnt); end
            end
            if (k == 252) begin
                n_cmp++; if (a_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", a_cnt); end
            end
        end
        n_cmp++; if (a_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", a_cnt); end
        a_iv = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [35:0] q [$];
        logic [35:0] e;
        logic [35:0] prev_out;
        logic        stall_prev;
        int          emits;
        int          cyc;
        emits = 0; cyc = 0; stall_prev = 1'b0; prev_out = '0;
        while (emits < 10000 && cyc < 60000) begin
            if (stall_prev) begin
                n_cmp++; if (a_ov !== 1'b1 || {a_err, a_od} !== prev_out)
                    begin n_bad++; $display("FAIL rnd_stable cyc%0d: got v=%b %h want v=1 %h", cyc, a_ov, {a_err, a_od}, prev_out); end
            end
            a_iv  = ($urandom_range(0, 1) == 1);
            a_sel = 6'($urandom_range(0, 63));
            a_or  = ($urandom_range(0, 1) == 1);
            if (a_ov && a_or) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_dup cyc%0d: got %h want nothing", cyc, {a_err, a_od});
                end else begin
                    e = q.pop_front();
                    if ({a_err, a_od} !== e) begin n_bad++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, {a_err, a_od}, e); end
                end
                emits++;
            end
            if (a_iv && a_ir) q.push_back(exp_a(a_sel));
            stall_prev = a_ov && !a_or;
            prev_out   = {a_err, a_od};
            step();
            cyc++;
        end
        n_cmp++; if (emits < 10000) begin n_bad++; $display("FAIL rnd_budget: got %0d emits want 10000", emits); end
        a_iv = 1'b0; a_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (a_ov) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_drain_dup: got %h want nothing", {a_err, a_od});
                end else begin
                    e = q.pop_front();
                    if ({a_err, a_od} !== e) begin n_bad++; $display("FAIL rnd_drain: got %h want %h", {a_err, a_od}, e); end
                end
            end
            step();
        end
        n_cmp++; if (q.size() != 0 || a_ov !== 1'b0)
            begin n_bad++; $display("FAIL rnd_loss: got %0d left v=%b want 0 left v=0", q.size(), a_ov); end
        n_cmp++; if (a_cnt !== 8'd255) begin n_bad++; $display("FAIL rnd_cnt_sat: got %0d want 255", a_cnt); end
    endtask

    task automatic test_reset_mid_full();
        a_or = 1'b0;
        a_iv = 1'b1; a_sel = 6'd3;
        step();
        a_sel = 6'd4;
        step();
        n_cmp++; if (a_ir !== 1'b0 || a_od !== lane_a(3))
            begin n_bad++; $display("FAIL rmf_full: got rdy=%b d=%h want rdy=0 d=%h", a_ir, a_od, lane_a(3)); end
        a_iv = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_cnt !== 8'd0)
            begin n_bad++; $display("FAIL rmf_async: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", a_ov, a_ir, a_cnt); end
        @(negedge clk);
        rst = 1'b0;
        a_iv = 1'b1; a_sel = 6'd7; a_or = 1'b1;
        step();
        n_cmp++; if (a_ov !== 1'b1 || a_od !== lane_a(7))
            begin n_bad++; $display("FAIL rmf_next: got v=%b d=%h want v=1 d=%h", a_ov, a_od, lane_a(7)); end
        a_iv = 1'b0;
        step();
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL rmf_drain: got out_valid %b want 0", a_ov); end
    endtask

    task automatic test_small_configs();
        logic [15:0] want;
        b_or = 1'b1; c_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_iv = 1'b1; b_sel = 3'(i);
            c_iv = 1'b1; c_sel = 3'(i);
            step();
            want = 16'hB000 + 16'(i);
            n_cmp++; if (b_ov !== 1'b1 || b_od !== want || b_err !== 1'b0)
                begin n_bad++; $display("FAIL cfg8_lane%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", i, b_ov, b_od, b_err, want); end
            want = (i < 5) ? 16'hC000 + 16'(i) : 16'h0000;
            n_cmp++; if (c_ov !== 1'b1 || c_od !== want || c_err !== (i >= 5))
                begin n_bad++; $display("FAIL cfg5_lane%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b", i, c_ov, c_od, c_err, want, (i >= 5)); end
        end
        n_cmp++; if (c_cnt !== 8'd3) begin n_bad++; $display("FAIL cfg5_err_count: got %0d want 3", c_cnt); end
        n_cmp++; if (b_cnt !== 8'd0) begin n_bad++; $display("FAIL cfg8_err_count: got %0d want 0", b_cnt); end
        b_iv = 1'b0; c_iv = 1'b0;
        step();
        n_cmp++; if (b_ov !== 1'b0 || c_ov !== 1'b0)
            begin n_bad++; $display("FAIL cfg_drain: got %b/%b want 0/0", b_ov, c_ov); end
    endtask

    initial begin
        rst = 1'b1;
        a_iv = 1'b0; a_or = 1'b0; a_sel = '0;
        b_iv = 1'b0; b_or = 1'b0; b_sel = '0;
        c_iv = 1'b0; c_or = 1'b0; c_sel = '0;
        for (int i = 0; i < 40; i++) a_dat[35*i +: 35] = lane_a(i);
        for (int i = 0; i < 8; i++)  b_dat[16*i +: 16] = 16'hB000 + 16'(i);
        for (int i = 0; i < 5; i++)  c_dat[16*i +: 16] = 16'hC000 + 16'(i);
        #1;
        test_reset();
        test_back_to_back();
        test_out_of_range();
        test_stall();
        test_saturate();
        test_random();
        test_reset_mid_full();
        test_small_configs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_nxw_reg.md
# mux_nxw_reg

Parametrised, registered N-input by W-bit selector with a valid/ready handshake and a 2-entry skid buffer. It generalises the fixed 40x35b combinational selectors used between the issue, decode and LSU stages. Data moves at full throughput with 1-cycle latency. Out-of-range selects produce zero data and a flag instead of X, and a saturating counter records them for FPGA debug.

## Interface
- NUM_IN, 40, number of input lanes (>=2)
- WIDTH, 35, bits per lane
- SEL_W, 6, select width; elaboration error if 2**SEL_W < NUM_IN
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input transfer request
- in_ready  output  1  block can accept this cycle
- in_data  input  NUM_IN*WIDTH  packed lanes; lane i = in_data[WIDTH*i+WIDTH-1 : WIDTH*i]
- in_select  input  SEL_W  lane index, sampled with in_data
- out_valid  output  1  out_data/out_sel_err valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  selected lane
- out_sel_err  output  1  the transfer had in_select >= NUM_IN
- err_count  output  8  saturating count of accepted out-of-range transfers

## Operation
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- At accept, the captured payload is {err, data}:
  - If in_select < NUM_IN: data = lane[in_select], err = 0.
  - Otherwise: data = 0, err = 1.
- Storage is an output register (OR) plus a skid register (SK), each with a valid bit.
- State is derived from the valid bits: EMPTY (OR=0, SK=0), ONE (OR=1, SK=0), FULL (OR=1, SK=1). SK valid with OR empty is illegal.
- in_ready = ~SK.valid, driven directly from a register with no combinational path from out_ready.
- Transitions:
  - EMPTY: accept -> ONE, OR <= payload.
  - ONE, accept & emit -> ONE, OR <= new payload.
  - ONE, accept & ~emit -> FULL, SK <= payload, OR unchanged.
  - ONE, ~accept & emit -> EMPTY.
  - ONE, neither -> hold.
  - FULL: no accept possible. Emit -> ONE, OR <= SK. Otherwise hold.
- Ordering is strict FIFO; no payload is dropped or duplicated.
- out_data and out_sel_err are stable while out_valid=1 and out_ready=0.
- err_count increments by 1 on each accept with err=1 and saturates at 255. It counts at accept, not at emit.
- Parameter arithmetic: the lane offset is WIDTH*in_select, computed at SEL_W + clog2(WIDTH) + 1 bits. The range compare is done at SEL_W+1 bits so NUM_IN = 2**SEL_W works.

## Timing
- Latency: accept in cycle n -> out_valid=1 with that payload in cycle n+1 (EMPTY or ONE-with-emit path).
- Throughput: 1 transfer/cycle while out_ready=1.
- in_ready falls in the cycle after the ONE->FULL transition. It rises in the cycle after the FULL emit.
- Reset (async assert, any state): out_valid=0, SK.valid=0, out_data=0, out_sel_err=0, err_count=0, in_ready=1.
- Inputs are ignored while rst=1. The first accept is possible in the first rising edge with rst=0.
- Reset asserted mid-FULL discards both entries; nothing is emitted after reset.
- Simultaneous accept and emit in ONE are legal every cycle.
- Simultaneous accept and emit in FULL cannot occur, because in_ready=0.

## Test plan
- NUM_IN=40, WIDTH=35, lane i = 35'h1_0000_0000+i; select 0..39 back-to-back with out_ready=1 -> out_data 35'h1_0000_0000..35'h1_0000_0027 on consecutive cycles, 1-cycle latency, out_sel_err=0.
- Select 40, then 63 -> out_data=0 with out_sel_err=1 for both; err_count=2.
- out_ready=0 while sending selects 5 then 6 -> cycle after 2nd accept in_ready=0 and out_data=lane5. Raise out_ready -> lane5, then lane6 emitted; in_ready=1 one cycle after the lane5 emit.
- Random valid/ready (50%/50%), 10k transfers against a scoreboard model -> no loss, reorder or duplicate; out_data stable whenever stalled.
- 300 out-of-range accepts -> err_count saturates at 255 and holds.
- Assert rst while FULL (OR=lane3, SK=lane4) -> out_valid=0 immediately (async), in_ready=1. After release, select 7 -> lane7 is the next output; lanes 3/4 never appear.
- Re-run the first test with NUM_IN=8, WIDTH=16, SEL_W=3 and NUM_IN=5, SEL_W=3 (select 5..7 -> err).
